// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory controller: access sizes and FSM states.
package dm_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;
    localparam logic [1:0] MEM_ILL  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

endpackage

// File: rtl/dm_align.sv
// Combinational lane logic: alignment check, store merge into the old word,
// and load extraction with sign/zero extension.
module dm_align
    import dm_pkg::*;
(
    input  logic [1:0]  lo,
    input  logic [1:0]  mem_op,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    input  logic        load_unsigned,
    output logic        bad,
    output logic [31:0] new_word,
    output logic [31:0] rdata
);

    logic [31:0] sh;
    logic [7:0]  lane;
    logic [15:0] half;

    assign sh   = word >> {lo, 3'b000};
    assign lane = sh[7:0];
    assign half = lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        bad      = 1'b0;
        new_word = word;
        rdata    = word;
        case (mem_op)
            MEM_BYTE: begin
                new_word[{lo, 3'b000} +: 8] = wdata[7:0];
                rdata = {{24{~load_unsigned & lane[7]}}, lane};
            end
            MEM_HALF: begin
                bad = lo[0];
                if (lo[1]) new_word[31:16] = wdata[15:0];
                else       new_word[15:0]  = wdata[15:0];
                rdata = {{16{~load_unsigned & half[15]}}, half};
            end
            MEM_WORD: begin
                bad      = |lo;
                new_word = wdata;
            end
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller: request latch, wait-state FSM, word array; the array
// write and load sample both happen on the edge that enters RESP.
module dm_ctrl
    import dm_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int WAIT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [1:0]        mem_op,
    input  logic              load_unsigned,
    output logic              ready,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              wdone,
    output logic              err
);

    localparam int         DEPTH   = 2 ** (ADDR_W - 2);
    localparam logic [3:0] WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    logic [31:0] mem [DEPTH];

    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic              go_resp, acc;
    logic              l_we, l_uns;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_wdata;
    logic [1:0]        l_op;

    // Access fields: live inputs when entering RESP straight from accept,
    // latched copy when coming out of WAIT.
    logic              a_we, a_uns;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata, a_word, new_word, ld_data;
    logic [1:0]        a_op;
    logic              bad;

    assign ready   = (state != S_WAIT);
    assign acc     = req && ready;
    assign a_we    = (state == S_WAIT) ? l_we    : we;
    assign a_uns   = (state == S_WAIT) ? l_uns   : load_unsigned;
    assign a_addr  = (state == S_WAIT) ? l_addr  : addr;
    assign a_wdata = (state == S_WAIT) ? l_wdata : wdata;
    assign a_op    = (state == S_WAIT) ? l_op    : mem_op;
    assign a_word  = mem[a_addr[ADDR_W-1:2]];

    dm_align u_align (
        .lo            (a_addr[1:0]),
        .mem_op        (a_op),
        .wdata         (a_wdata),
        .word          (a_word),
        .load_unsigned (a_uns),
        .bad           (bad),
        .new_word      (new_word),
        .rdata         (ld_data)
    );

    always_comb begin
        state_nx = state;
        go_resp  = 1'b0;
        case (state)
            S_IDLE, S_RESP: begin
                state_nx = S_IDLE;
                if (acc) begin
                    if (WAIT > 0) begin
                        state_nx = S_WAIT;
                    end else begin
                        state_nx = S_RESP;
                        go_resp  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = S_RESP;
                    go_resp  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            rvalid  <= 1'b0;
            wdone   <= 1'b0;
            err     <= 1'b0;
            rdata   <= 32'd0;
            l_we    <= 1'b0;
            l_uns   <= 1'b0;
            l_addr  <= '0;
            l_wdata <= 32'd0;
            l_op    <= MEM_BYTE;
        end else begin
            state  <= state_nx;
            rvalid <= go_resp && !a_we && !bad;
            wdone  <= go_resp &&  a_we && !bad;
            err    <= go_resp && bad;
            if (go_resp && !a_we && !bad) rdata <= ld_data;
            if (acc) begin
                l_we    <= we;
                l_uns   <= load_unsigned;
                l_addr  <= addr;
                l_wdata <= wdata;
                l_op    <= mem_op;
                cnt     <= WAIT_M1;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Array is never reset; a store colliding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && go_resp && a_we && !bad)
            mem[a_addr[ADDR_W-1:2]] <= new_word;
    end

endmodule

// File: doc/dm_ctrl.md
# dm_ctrl

Parametrised data-memory controller for the MIPS CPU: byte-addressed, word-organised RAM with byte/half/word stores and sign- or zero-extending loads. It has a request/response handshake and a configurable wait-state count so the pipeline can be tested against slow memory. Misaligned and illegal accesses are flagged as errors instead of being silently truncated. It sits between the MEM stage and the RAM array and replaces the fixed 128-word, zero-latency data memory.

## Interface
- ADDR_W, 9, byte-address width; the array holds 2^(ADDR_W-2) 32-bit words.
- WAIT, 0, extra wait cycles per access, 0..15.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  1  access request; sampled when ready=1.
- we  in  1  1 = store, 0 = load.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- mem_op  in  2  00 byte, 01 half, 10 word, 11 illegal.
- load_unsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- ready  out  1  controller can accept a request this cycle.
- rvalid  out  1  one-cycle pulse: rdata valid for a completed load.
- rdata  out  32  load result; holds its value until the next rvalid.
- wdone  out  1  one-cycle pulse: store committed.
- err  out  1  one-cycle pulse: access rejected (misaligned or illegal op).

## Operation
- **Accept.** A request is accepted when req && ready.
  - addr, we, wdata, mem_op and load_unsigned are latched in that cycle.
  - Inputs are don't-care at all other times.
- **Word index and byte lane.**
  - Word index is addr[ADDR_W-1:2]. Lanes are little-endian: lane k is bits [8k+7:8k].
  - Byte access uses lane addr[1:0].
  - Half access uses lanes {1,0} when addr[1]=0 and lanes {3,2} when addr[1]=1.
- **Error check.**
  - Misaligned cases: half with addr[0]=1; word with addr[1:0]≠00.
  - Misaligned or mem_op=11 makes the access an error: no write occurs, rdata is unchanged, and err pulses in place of rvalid/wdone.
- **Store.** Only the addressed lanes are updated; all other bytes of the word are preserved.
- **Load.** The addressed byte or half is extracted to bit 0 and extended per load_unsigned. A word load returns the word unchanged.
- **States.**
  - IDLE: ready=1. On accept, go to WAIT if WAIT>0, else RESP.
  - WAIT: ready=0. A counter loads WAIT-1 on entry. Leave for RESP when the counter reaches 0.
  - RESP: exactly one of rvalid/wdone/err is 1 and ready=1. On accept, go to WAIT or RESP as from IDLE; otherwise go to IDLE.
- **Array update and sampling.** The array write and the load read both happen on the edge that enters RESP. A load accepted in the cycle a prior store is in RESP therefore sees the stored data.
- **Array reset.** Array contents are not reset.

## Timing
- **Latency.** From the accept edge to the response pulse is WAIT+1 cycles.
- **Throughput.**
  - WAIT=0: one access per cycle (RESP→RESP back-to-back).
  - WAIT=N: one access per N+1 cycles.
- **Reset values.** ready=1, rvalid=0, wdone=0, err=0, rdata=0; state IDLE; counter 0.
- **Reset mid-operation.**
  - An access in WAIT is dropped: no write, no response.
  - A store whose RESP edge coincides with rst=1 is not committed; reset wins.
- **Simultaneous events.**
  - req during WAIT is ignored. The requester must hold req until it sees ready.
  - A response and a new accept in the same cycle are legal, and both are handled.
- **Address wrap.** addr is exactly ADDR_W bits, so there is no wrap or aliasing inside the block. The upper-bit truncation is the caller's concern.
- **Error latency.** An error response takes the same WAIT+1 latency as a normal access.

## Structure
- **Package dm_pkg** holds:
  - mem_op encodings: MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10, MEM_ILL=2'b11.
  - The state enum {S_IDLE, S_WAIT, S_RESP}.
- **Sub-module dm_align** (combinational) holds:
  - the misalign/illegal check;
  - the store merge (old word, wdata, addr[1:0], mem_op → new word);
  - the load extract (word, addr[1:0], mem_op, load_unsigned → rdata).
- **Top level** holds the FSM, the wait counter, the request latch and the array.

## Test plan
- **Word round trip, WAIT=0.**
  - Store 0xDEADBEEF at addr 0x010: wdone at accept+1.
  - Load word at 0x010: rvalid at accept+1 with rdata=0xDEADBEEF.
- **Byte store preserves other lanes.**
  - Word 0x11223344 at 0x020, then byte store 0xAA at 0x022.
  - Word load returns 0x11AA3344.
- **Sign/zero extension.**
  - Word 0x80FF7F01 at 0x030.
  - Byte load 0x032 signed returns 0xFFFFFFFF; unsigned returns 0x000000FF.
  - Half load 0x032 signed returns 0xFFFF80FF.
  - Byte load 0x030 signed returns 0x00000001.
- **Misaligned and illegal.**
  - Half store at 0x041 → err at accept+1, no wdone, memory unchanged.
  - Word load at 0x042 → err, rdata holds its previous value.
  - mem_op=11 → err.
- **WAIT=3.**
  - Store accepted at cycle t: ready=0 for cycles t+1..t+3, wdone at t+4.
  - A load requested at t+2 is not accepted until t+4, and returns the new data at t+8.
- **Reset mid-operation.**
  - WAIT=3, store 0x12345678 to 0x050 over old value 0, rst at accept+2.
  - No wdone; ready=1 after reset; subsequent load of 0x050 returns 0.
